// File: rtl/scan_chain_sequencer.sv
// rtl/scan_chain_sequencer.sv - serial scan-chain shift/capture/latch sequencer
module scan_chain_sequencer #(
   parameter int WIDTH = 8,
   parameter int DIV   = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] data_in,
   input  logic             scan_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_out,
   output logic             scan_clk,
   output logic             scan_en,
   output logic             scan_data,
   output logic             scan_latch
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = $clog2(WIDTH);
   localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, LATCH} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sr, sr_nx;
   logic [PW-1:0]    phase, phase_nx;
   logic [BW-1:0]    bit_cnt, bit_cnt_nx;
   logic             phase_end;
   logic             scan_nx;

   assign phase_end = (phase == PHASE_LAST);
   assign scan_nx   = (state_nx == SETUP) || (state_nx == HIGH) || (state_nx == LOW);

   always_comb begin
      state_nx   = state;
      sr_nx      = sr;
      phase_nx   = phase;
      bit_cnt_nx = bit_cnt;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nx   = SETUP;
               sr_nx      = data_in;
               phase_nx   = '0;
               bit_cnt_nx = '0;
            end
         end
         SETUP, LOW: begin
            if (phase_end) begin
               state_nx = HIGH;
               phase_nx = '0;
            end else begin
               phase_nx = phase + PW'(1);
            end
         end
         HIGH: begin
            // scan_in is captured as the scan clock falls, then the next MSB goes out
            if (phase_end) begin
               phase_nx = '0;
               sr_nx    = {sr[WIDTH-2:0], scan_in};
               if (bit_cnt == BIT_LAST) begin
                  state_nx = LATCH;
               end else begin
                  state_nx   = LOW;
                  bit_cnt_nx = bit_cnt + BW'(1);
               end
            end else begin
               phase_nx = phase + PW'(1);
            end
         end
         LATCH:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (abort && (state != IDLE)) begin
         state_nx   = IDLE;
         phase_nx   = '0;
         bit_cnt_nx = '0;
      end
   end

   // Outputs are registered from the next-state view so they align with the state they describe
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         sr         <= '0;
         phase      <= '0;
         bit_cnt    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         data_out   <= '0;
         scan_clk   <= 1'b0;
         scan_en    <= 1'b0;
         scan_data  <= 1'b0;
         scan_latch <= 1'b0;
      end else begin
         state      <= state_nx;
         sr         <= sr_nx;
         phase      <= phase_nx;
         bit_cnt    <= bit_cnt_nx;
         busy       <= (state_nx != IDLE);
         scan_en    <= scan_nx;
         scan_clk   <= (state_nx == HIGH);
         scan_data  <= scan_nx ? sr_nx[WIDTH-1] : 1'b0;
         scan_latch <= (state_nx == LATCH);
         done       <= (state == LATCH) && !abort;
         if ((state == LATCH) && !abort) begin
            data_out <= sr;
         end
      end
   end

endmodule
